sprite_linebuf_dual: RTL and testbench

Double-buffered sprite line buffer. It sits between the sprite line renderer, which read-modify-writes the render bank, and the composer, which reads the display bank one line later. Entries the composer reads are cleared behind it. A background sweep clears the off-screen tail of the display bank, so every bank is all-zero when it becomes the render bank.

---
 rtl/sprite_linebuf_dual.sv | 121 ++++++++++++
 tb/tb_sprite_linebuf_dual.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sprite_linebuf_dual.sv
// Double-buffered sprite line buffer: renderer read-modify-writes one bank while the
// composer reads the other, clearing entries behind it and sweeping the off-screen tail.
module sprite_linebuf_dual #(
  parameter int ACTIVE_WIDTH = 640,
  parameter int DEPTH_LOG2   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_render_start,
  output logic                  init_busy,
  output logic                  sweep_overrun,
  input  logic [DEPTH_LOG2-1:0] ren_rdidx,
  output logic [15:0]           ren_rddata,
  input  logic [DEPTH_LOG2-1:0] ren_wridx,
  input  logic [15:0]           ren_wrdata,
  input  logic                  ren_wren,
  input  logic [DEPTH_LOG2-1:0] disp_rdidx,
  input  logic                  disp_rden,
  output logic [15:0]           disp_rddata,
  output logic                  disp_valid
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nxt;

  logic [DEPTH_LOG2-1:0] init_cnt;
  logic [DEPTH_LOG2:0]   sweep_ptr;
  logic                  sel;
  logic                  clr_pend, clr_bank;
  logic [DEPTH_LOG2-1:0] clr_idx;
  logic                  swap, sweep_en;

  logic [15:0] bank0 [DEPTH];
  logic [15:0] bank1 [DEPTH];
  logic [1:0]                  we;
  logic [1:0][DEPTH_LOG2-1:0]  wa;
  logic [1:0][15:0]            wd;

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    init_busy = (state == INIT);
    if (state == INIT && (&init_cnt)) state_nxt = RUN;
  end

  assign swap     = (state == RUN) && line_render_start;
  // Sweep yields to any pending clear, including one aimed at the render bank after a swap.
  assign sweep_en = (state == RUN) && !clr_pend && !sweep_ptr[DEPTH_LOG2];

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      we[b] = 1'b0;
      wa[b] = '0;
      wd[b] = '0;
      if (state == INIT) begin
        we[b] = 1'b1;
        wa[b] = init_cnt;
      end else if (clr_pend && clr_bank == b[0]) begin
        we[b] = 1'b1;
        wa[b] = clr_idx;
      end else if (sel == b[0]) begin
        we[b] = ren_wren;
        wa[b] = ren_wridx;
        wd[b] = ren_wrdata;
      end else if (sweep_en) begin
        we[b] = 1'b1;
        wa[b] = sweep_ptr[DEPTH_LOG2-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we[0]) bank0[wa[0]] <= wd[0];
    if (we[1]) bank1[wa[1]] <= wd[1];
  end

  always_ff @(posedge clk) begin
    if (rst || state == INIT) begin
      ren_rddata  <= '0;
      disp_rddata <= '0;
      disp_valid  <= 1'b0;
    end else begin
      ren_rddata <= sel ? bank1[ren_rdidx] : bank0[ren_rdidx];
      disp_valid <= disp_rden;
      if (disp_rden) disp_rddata <= sel ? bank0[disp_rdidx] : bank1[disp_rdidx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel           <= 1'b0;
      sweep_ptr     <= (DEPTH_LOG2+1)'(ACTIVE_WIDTH);
      sweep_overrun <= 1'b0;
      init_cnt      <= '0;
      clr_pend      <= 1'b0;
      clr_bank      <= 1'b0;
      clr_idx       <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + 1'b1;
      clr_pend <= 1'b0;
    end else begin
      clr_pend <= disp_rden;
      if (disp_rden) begin
        clr_bank <= ~sel;
        clr_idx  <= disp_rdidx;
      end
      if (swap) begin
        sel       <= ~sel;
        sweep_ptr <= (DEPTH_LOG2+1)'(ACTIVE_WIDTH);
        if (!sweep_ptr[DEPTH_LOG2]) sweep_overrun <= 1'b1;
      end else if (sweep_en) begin
        sweep_ptr <= sweep_ptr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sprite_linebuf_dual.sv
// Directed bench for sprite_linebuf_dual; expected read data is queued at issue time
// and a negedge monitor pops and compares as results appear.
module tb_sprite_linebuf_dual;
  logic        clk = 1'b0;
  logic        rst;
  logic        line_render_start;
  logic        init_busy, sweep_overrun;
  logic [9:0]  ren_rdidx, ren_wridx, disp_rdidx;
  logic [15:0] ren_rddata, ren_wrdata, disp_rddata;
  logic        ren_wren, disp_rden, disp_valid;

  sprite_linebuf_dual #(.ACTIVE_WIDTH(640), .DEPTH_LOG2(10)) dut (
    .clk(clk), .rst(rst), .line_render_start(line_render_start),
    .init_busy(init_busy), .sweep_overrun(sweep_overrun),
    .ren_rdidx(ren_rdidx), .ren_rddata(ren_rddata),
    .ren_wridx(ren_wridx), .ren_wrdata(ren_wrdata), .ren_wren(ren_wren),
    .disp_rdidx(disp_rdidx), .disp_rden(disp_rden),
    .disp_rddata(disp_rddata), .disp_valid(disp_valid)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;
  logic [15:0] ren_q[$];
  logic [15:0] disp_q[$];
  logic ren_chk = 1'b0, ren_chk_d = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) ren_chk_d <= ren_chk;

  always @(negedge clk) begin
    if (disp_valid) begin
      if (disp_q.size() == 0) chk("disp_unexpected_valid", 1, 0);
      else chk("disp_rddata", disp_rddata, disp_q.pop_front());
    end
    if (ren_chk_d) begin
      if (ren_q.size() == 0) chk("ren_queue_underflow", 1, 0);
      else chk("ren_rddata", ren_rddata, ren_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic ren_write(input logic [9:0] idx, input logic [15:0] d);
    ren_wridx = idx; ren_wrdata = d; ren_wren = 1'b1;
    tick();
    ren_wren = 1'b0;
  endtask

  task automatic ren_read(input logic [9:0] idx, input logic [15:0] exp);
    ren_rdidx = idx; ren_chk = 1'b1; ren_q.push_back(exp);
    tick();
    ren_chk = 1'b0;
  endtask

  task automatic disp_read(input logic [9:0] idx, input logic [15:0] exp);
    disp_rdidx = idx; disp_rden = 1'b1; disp_q.push_back(exp);
    tick();
    disp_rden = 1'b0;
  endtask

  task automatic swap();
    line_render_start = 1'b1;
    tick();
    line_render_start = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; line_render_start = 1'b0;
    ren_rdidx = '0; ren_wridx = '0; ren_wrdata = '0; ren_wren = 1'b0;
    disp_rdidx = '0; disp_rden = 1'b0;
    idle(3);
    chk("reset_init_busy", init_busy, 1);
    chk("reset_disp_valid", disp_valid, 0);
    chk("reset_ren_rddata", ren_rddata, 0);
    chk("reset_disp_rddata", disp_rddata, 0);
    chk("reset_sweep_overrun", sweep_overrun, 0);

    // Post-reset clear length; a swap request during INIT must be ignored.
    rst = 1'b0;
    n = 0;
    while (init_busy && n < 2000) begin
      line_render_start = (n == 100);
      tick();
      n++;
    end
    line_render_start = 1'b0;
    chk("init_busy_cycles", n, 1024);

    // Fresh banks read zero; wait out the initial tail sweep.
    ren_read(10'd0, 16'h0);
    ren_read(10'd1023, 16'h0);
    disp_read(10'd3, 16'h0);
    disp_read(10'd639, 16'h0);
    idle(400);
    chk("overrun_after_init", sweep_overrun, 0);

    // Render write/read, then swap and read-with-clear on the display side.
    ren_write(10'd5, 16'h1A37);
    ren_read(10'd5, 16'h1A37);
    idle(2);
    swap();
    disp_read(10'd5, 16'h1A37);
    idle(1);
    disp_read(10'd5, 16'h0000);
    idle(400);

    // Off-screen entry is removed by the sweep, not the composer.
    ren_write(10'd900, 16'h0312);
    swap();
    idle(400);
    swap();
    idle(400);
    ren_read(10'd900, 16'h0000);
    chk("overrun_after_full_sweeps", sweep_overrun, 0);

    // Same-cycle write and read: read-first returns the old value.
    ren_wridx = 10'd12; ren_wrdata = 16'h2105; ren_wren = 1'b1;
    ren_rdidx = 10'd12; ren_chk = 1'b1; ren_q.push_back(16'h0000);
    tick();
    ren_wren = 1'b0; ren_chk = 1'b0;
    ren_read(10'd12, 16'h2105);

    // Composer read coinciding with swap uses the pre-swap display bank,
    // and the clear lands in that bank, now the render bank.
    ren_write(10'd7, 16'h0BEE);
    swap();
    idle(400);
    disp_rdidx = 10'd7; disp_rden = 1'b1; line_render_start = 1'b1;
    disp_q.push_back(16'h0BEE);
    tick();
    disp_rden = 1'b0; line_render_start = 1'b0;
    idle(1);
    ren_read(10'd7, 16'h0000);
    chk("overrun_after_read_swap", sweep_overrun, 0);
    idle(400);

    // Full back-to-back line read starves the sweep; swap right after flags overrun.
    swap();
    for (int i = 0; i < 640; i++) disp_read(10'(i), (i == 12) ? 16'h2105 : 16'h0000);
    chk("overrun_before_late_swap", sweep_overrun, 0);
    swap();
    chk("overrun_set", sweep_overrun, 1);
    idle(400);
    chk("overrun_sticky", sweep_overrun, 1);
    ren_read(10'd12, 16'h0000);

    idle(3);
    chk("disp_queue_drained", disp_q.size(), 0);
    chk("ren_queue_drained", ren_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
